// File: rtl/load_seq_fsm_if.sv
// load_seq_fsm_if: start/stage/status bundle of the load sequencer.
// master = sequencer side, slave = board controller plus sub-engines.
interface load_seq_fsm_if #(
  parameter int N_STG = 2,
  parameter int SW    = 4
) ();
  logic             load_ram_en;
  logic             abort_err;
  logic [N_STG-1:0] stg_en;
  logic [N_STG-1:0] stg_done;
  logic [N_STG-1:0] stg_error;
  logic             seq_busy;
  logic             seq_done;
  logic             seq_error;
  logic [SW-1:0]    err_stg;
  logic [1:0]       err_code;

  modport master (
    input  load_ram_en,
    input  abort_err,
    input  stg_done,
    input  stg_error,
    output stg_en,
    output seq_busy,
    output seq_done,
    output seq_error,
    output err_stg,
    output err_code
  );

  modport slave (
    output load_ram_en,
    output abort_err,
    output stg_done,
    output stg_error,
    input  stg_en,
    input  seq_busy,
    input  seq_done,
    input  seq_error,
    input  err_stg,
    input  err_code
  );
endinterface

// File: rtl/load_seq_fsm.sv
// load_seq_fsm: launches N_STG load stages in order, with retry.
// Optional per-stage watchdog: define LOAD_SEQ_TIMEOUT_EN.
module load_seq_fsm #(
  parameter int N_STG       = 2,
  parameter int MAX_RETRY   = 0,
  parameter int TIMEOUT_CYC = 1048575,
  parameter int SW          = 4
) (
  input logic            sys_clk,
  input logic            glbl_rst,
  load_seq_fsm_if.master bus
);

  // A misconfigured instance never leaves IDLE.
  localparam bit CFG_OK =
    (N_STG >= 1) && (N_STG <= 16) &&
    ((2 ** SW) >= N_STG) &&
    (MAX_RETRY >= 0) && (MAX_RETRY <= 7) &&
    (TIMEOUT_CYC >= 1);

  localparam logic [1:0] EC_STG   = 2'b01;
  localparam logic [1:0] EC_ABORT = 2'b10;
  localparam logic [1:0] EC_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    idx_q, idx_d;
  logic [2:0]       retry_q, retry_d;
  logic [N_STG-1:0] stg_en_q, stg_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [SW-1:0]    err_stg_q, err_stg_d;
  logic [1:0]       err_code_q, err_code_d;

  logic cur_done;
  logic cur_err;
  logic idx_ok;
  logic wd_hit;

  // Pick the done/error bits of the active stage only.
  always_comb begin
    cur_done = 1'b0;
    cur_err  = 1'b0;
    idx_ok   = 1'b0;
    for (int i = 0; i < N_STG; i++) begin
      if (idx_q == SW'(i)) begin
        cur_done = bus.stg_done[i];
        cur_err  = bus.stg_error[i];
        idx_ok   = 1'b1;
      end
    end
  end

`ifdef LOAD_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_q, wd_d;

  // Watchdog: cleared on launch, counts WAIT cycles.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_LAUNCH) begin
      wd_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_d = wd_q + WDW'(1);
    end
  end

  assign wd_hit = (state_q == S_WAIT) &&
                  (wd_q == WDW'(TIMEOUT_CYC - 1));

  // Watchdog register.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Next state, stage index, retry count and registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_stg_d  = err_stg_q;
    err_code_d = err_code_q;
    busy_d     = 1'b0;
    stg_en_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.load_ram_en && CFG_OK) begin
          err_stg_d  = '0;
          err_code_d = '0;
          idx_d      = '0;
          retry_d    = '0;
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!idx_ok) begin
          state_d    = S_IDLE;
          idx_d      = '0;
          retry_d    = '0;
          err_stg_d  = '0;
          err_code_d = '0;
        end else if (bus.abort_err) begin
          error_d    = 1'b1;
          err_stg_d  = idx_q;
          err_code_d = EC_ABORT;
          state_d    = S_IDLE;
        end else if (wd_hit) begin
          error_d    = 1'b1;
          err_stg_d  = idx_q;
          err_code_d = EC_TMO;
          state_d    = S_IDLE;
        end else if (cur_err) begin
          if (retry_q < 3'(MAX_RETRY)) begin
            retry_d = retry_q + 3'd1;
            state_d = S_LAUNCH;
          end else begin
            error_d    = 1'b1;
            err_stg_d  = idx_q;
            err_code_d = EC_STG;
            state_d    = S_IDLE;
          end
        end else if (cur_done) begin
          if (idx_q == SW'(N_STG - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + SW'(1);
            retry_d = '0;
            state_d = S_LAUNCH;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        idx_d      = '0;
        retry_d    = '0;
        err_stg_d  = '0;
        err_code_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    for (int i = 0; i < N_STG; i++) begin
      stg_en_d[i] = (state_d == S_LAUNCH) &&
                    (idx_d == SW'(i));
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      stg_en_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_stg_q  <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      stg_en_q   <= stg_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_stg_q  <= err_stg_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.stg_en    = stg_en_q;
  assign bus.seq_busy  = busy_q;
  assign bus.seq_done  = done_q;
  assign bus.seq_error = error_q;
  assign bus.err_stg   = err_stg_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_load_seq_fsm.sv
// tb_load_seq_fsm: scripted and random stage responses vs a
// transaction-level model of the load sequence.
`timescale 1ns/1ps
module tb_load_seq_fsm;

  localparam int N  = 3;
  localparam int MR = 1;
  localparam int TO = 20;
  localparam int SW = 4;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_ABORT = 3;
  localparam int K_NONE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  load_seq_fsm_if #(.N_STG(N), .SW(SW)) bus ();

  load_seq_fsm #(
    .N_STG      (N),
    .MAX_RETRY  (MR),
    .TIMEOUT_CYC(TO),
    .SW         (SW)
  ) dut (
    .sys_clk (clk),
    .glbl_rst(rst),
    .bus     (bus)
  );

  int vec = 0;
  int bad = 0;

  int kind_q[$];
  int dly_q[$];
  int exp_stg[$];
  int exp_cyc[$];
  int exp_done;
  int exp_err_stg;
  int exp_code;
  int exp_end;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.load_ram_en = 1'b0;
    bus.abort_err   = 1'b0;
    bus.stg_done    = '0;
    bus.stg_error   = '0;
  endtask

  // Walk the response script launch by launch. Cycle 0 is the
  // first cycle after the start edge; each launch lasts dly+1.
  function automatic void model();
    int stage = 0;
    int retry = 0;
    int c = 0;
    exp_stg.delete();
    exp_cyc.delete();
    exp_done = 0;
    exp_err_stg = 0;
    exp_code = 0;
    exp_end = -1;
    for (int k = 0; k < kind_q.size(); k++) begin
      exp_stg.push_back(stage);
      exp_cyc.push_back(c);
      if (kind_q[k] == K_ABORT) begin
        exp_err_stg = stage;
        exp_code = 2;
        exp_end = c + dly_q[k] + 1;
        return;
      end
      if (kind_q[k] == K_NONE) begin
        exp_err_stg = stage;
        exp_code = 3;
        exp_end = c + TO + 1;
        return;
      end
      if (kind_q[k] == K_ERR || kind_q[k] == K_BOTH) begin
        if (retry < MR) begin
          retry++;
          c += dly_q[k] + 1;
        end else begin
          exp_err_stg = stage;
          exp_code = 1;
          exp_end = c + dly_q[k] + 1;
          return;
        end
      end else begin
        if (stage == N - 1) begin
          exp_done = 1;
          exp_end = c + dly_q[k] + 1;
          return;
        end
        stage++;
        retry = 0;
        c += dly_q[k] + 1;
      end
    end
  endfunction

  task automatic set_script(input int k0, input int d0,
                            input int k1, input int d1,
                            input int k2, input int d2,
                            input int k3, input int d3);
    kind_q.delete();
    dly_q.delete();
    kind_q.push_back(k0); dly_q.push_back(d0);
    kind_q.push_back(k1); dly_q.push_back(d1);
    kind_q.push_back(k2); dly_q.push_back(d2);
    kind_q.push_back(k3); dly_q.push_back(d3);
  endtask

  // Start one sequence, answer launches from the script with
  // noise on inactive bits, and check launches and outcome.
  task automatic run_script(input string name, input bit chain);
    int launches = 0;
    int pend = -1;
    int cur = 0;
    int knd = K_DONE;
    bit fin = 1'b0;
    model();
    bus.load_ram_en = 1'b1;
    tick();
    for (int c = 0; c < 400 && !fin; c++) begin
      clear_in();
      if (c == 0) begin
        vec++;
        if (bus.seq_busy !== 1'b1 || bus.err_code !== 2'b00 ||
            bus.err_stg !== '0) begin
          bad++;
          $display("FAIL %s start: busy=%b err_stg=%0d err_code=%b, required busy=1 err_stg=0 err_code=00",
                   name, bus.seq_busy, bus.err_stg, bus.err_code);
        end
      end
      if (bus.seq_done === 1'b1 || bus.seq_error === 1'b1) begin
        fin = 1'b1;
        vec++;
        if (c != exp_end || launches != exp_stg.size()) begin
          bad++;
          $display("FAIL %s end_timing: cycle %0d launches %0d, required cycle %0d launches %0d",
                   name, c, launches, exp_end, exp_stg.size());
        end
        vec++;
        if (bus.seq_done !== 1'(exp_done) ||
            bus.seq_error !== 1'(!exp_done) ||
            bus.err_stg !== SW'(exp_err_stg) ||
            bus.err_code !== 2'(exp_code) ||
            bus.seq_busy !== 1'b0 || bus.stg_en !== '0) begin
          bad++;
          $display("FAIL %s outcome: done=%b err=%b stg=%0d code=%b busy=%b en=%b, required done=%0d err=%0d stg=%0d code=%0d busy=0 en=0",
                   name, bus.seq_done, bus.seq_error, bus.err_stg,
                   bus.err_code, bus.seq_busy, bus.stg_en,
                   exp_done, !exp_done, exp_err_stg, exp_code);
        end
      end else begin
        vec++;
        if (bus.seq_busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy: busy=%b at cycle %0d, required 1",
                   name, bus.seq_busy, c);
        end
        if (bus.stg_en !== '0) begin
          vec++;
          if (launches >= exp_stg.size()) begin
            bad++;
            $display("FAIL %s extra_launch: stg_en=%b at cycle %0d, required none",
                     name, bus.stg_en, c);
          end else if (c != exp_cyc[launches] ||
                       bus.stg_en !== N'(1 << exp_stg[launches])) begin
            bad++;
            $display("FAIL %s launch: stg_en=%b at cycle %0d, required stg_en=%b at cycle %0d",
                     name, bus.stg_en, c,
                     N'(1 << exp_stg[launches]), exp_cyc[launches]);
          end
          if (launches < exp_stg.size()) begin
            cur = exp_stg[launches];
            pend = dly_q[launches];
            knd = kind_q[launches];
          end
          launches++;
          bus.stg_done  = N'($urandom);
          bus.stg_error = N'($urandom);
          bus.abort_err = 1'($urandom_range(0, 1));
        end else begin
          bus.stg_done  = N'($urandom) & ~(N'(1) << cur);
          bus.stg_error = N'($urandom) & ~(N'(1) << cur);
          if (pend > 0) begin
            pend--;
            if (pend == 0) begin
              if (knd == K_DONE || knd == K_BOTH)
                bus.stg_done = bus.stg_done | (N'(1) << cur);
              if (knd == K_ERR || knd == K_BOTH)
                bus.stg_error = bus.stg_error | (N'(1) << cur);
              if (knd == K_ABORT) begin
                bus.abort_err = 1'b1;
                bus.stg_done = bus.stg_done | (N'(1) << cur);
              end
            end
          end
        end
        bus.load_ram_en = ($urandom_range(0, 2) == 0);
        tick();
      end
    end
    if (!fin) begin
      vec++;
      bad++;
      $display("FAIL %s no_end: no seq_done/seq_error within budget, required at cycle %0d",
               name, exp_end);
    end
    if (!chain && fin) begin
      tick();
      vec++;
      if (bus.seq_done !== 1'b0 || bus.seq_error !== 1'b0 ||
          bus.seq_busy !== 1'b0 || bus.stg_en !== '0 ||
          bus.err_stg !== SW'(exp_err_stg) ||
          bus.err_code !== 2'(exp_code)) begin
        bad++;
        $display("FAIL %s after: done=%b err=%b busy=%b en=%b stg=%0d code=%b, required 0 0 0 0 stg=%0d code=%0d",
                 name, bus.seq_done, bus.seq_error, bus.seq_busy,
                 bus.stg_en, bus.err_stg, bus.err_code,
                 exp_err_stg, exp_code);
      end
    end
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    bus.load_ram_en = 1'b1;
    repeat (3) tick();
    vec++;
    if (bus.stg_en !== '0 || bus.seq_busy !== 1'b0 ||
        bus.seq_done !== 1'b0 || bus.seq_error !== 1'b0 ||
        bus.err_stg !== '0 || bus.err_code !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: en=%b busy=%b done=%b err=%b stg=%0d code=%b, required all 0",
               bus.stg_en, bus.seq_busy, bus.seq_done,
               bus.seq_error, bus.err_stg, bus.err_code);
    end
    rst = 1'b0;
    clear_in();
    tick();
    vec++;
    if (bus.stg_en !== '0 || bus.seq_busy !== 1'b0 ||
        bus.seq_done !== 1'b0 || bus.seq_error !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: en=%b busy=%b done=%b err=%b, required all 0",
               bus.stg_en, bus.seq_busy, bus.seq_done, bus.seq_error);
    end
  endtask

  task automatic test_all_done();
    set_script(K_DONE, 5, K_DONE, 5, K_DONE, 5, K_DONE, 5);
    run_script("all_done", 1'b0);
  endtask

  task automatic test_retry();
    set_script(K_DONE, 5, K_ERR, 3, K_DONE, 2, K_DONE, 4);
    run_script("retry", 1'b0);
  endtask

  task automatic test_retry_exhaust();
    set_script(K_ERR, 2, K_ERR, 3, K_DONE, 1, K_DONE, 1);
    run_script("retry_exhaust", 1'b0);
  endtask

  task automatic test_both();
    set_script(K_DONE, 1, K_BOTH, 2, K_BOTH, 1, K_DONE, 1);
    run_script("err_beats_done", 1'b0);
  endtask

  task automatic test_abort();
    set_script(K_ABORT, 3, K_DONE, 1, K_DONE, 1, K_DONE, 1);
    run_script("abort", 1'b0);
  endtask

  task automatic test_back_to_back();
    set_script(K_DONE, 1, K_DONE, 1, K_DONE, 1, K_DONE, 1);
    run_script("b2b_first", 1'b1);
    set_script(K_DONE, 2, K_ERR, 1, K_ERR, 2, K_DONE, 1);
    run_script("b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_in();
    bus.load_ram_en = 1'b1;
    tick();
    clear_in();
    vec++;
    if (bus.stg_en !== 3'b001) begin
      bad++;
      $display("FAIL mid_launch: stg_en=%b, required 001", bus.stg_en);
    end
    bus.stg_done = 3'b100;
    bus.load_ram_en = 1'b1;
    tick();
    clear_in();
    bus.stg_done = 3'b110;
    bus.load_ram_en = 1'b1;
    tick();
    clear_in();
    vec++;
    if (bus.stg_en !== '0 || bus.seq_busy !== 1'b1 ||
        bus.seq_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_stray: en=%b busy=%b done=%b, required en=000 busy=1 done=0",
               bus.stg_en, bus.seq_busy, bus.seq_done);
    end
    rst = 1'b1;
    tick();
    vec++;
    if (bus.stg_en !== '0 || bus.seq_busy !== 1'b0 ||
        bus.seq_done !== 1'b0 || bus.seq_error !== 1'b0 ||
        bus.err_code !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset: en=%b busy=%b done=%b err=%b code=%b, required all 0",
               bus.stg_en, bus.seq_busy, bus.seq_done,
               bus.seq_error, bus.err_code);
    end
    rst = 1'b0;
    bus.stg_done = 3'b001;
    bus.stg_error = 3'b010;
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_in();
      vec++;
      if (bus.stg_en !== '0 || bus.seq_busy !== 1'b0 ||
          bus.seq_done !== 1'b0 || bus.seq_error !== 1'b0) begin
        bad++;
        $display("FAIL mid_idle: en=%b busy=%b done=%b err=%b at %0d, required all 0",
                 bus.stg_en, bus.seq_busy, bus.seq_done,
                 bus.seq_error, i);
      end
    end
    set_script(K_DONE, 3, K_DONE, 4, K_DONE, 2, K_DONE, 1);
    run_script("after_reset", 1'b0);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      kind_q.delete();
      dly_q.delete();
      for (int k = 0; k < 12; k++) begin
        r = $urandom_range(0, 99);
        if (r < 70) kind_q.push_back(K_DONE);
        else if (r < 82) kind_q.push_back(K_ERR);
        else if (r < 90) kind_q.push_back(K_BOTH);
        else if (r < 96) kind_q.push_back(K_ABORT);
`ifdef LOAD_SEQ_TIMEOUT_EN
        else kind_q.push_back(K_NONE);
`else
        else kind_q.push_back(K_DONE);
`endif
        dly_q.push_back($urandom_range(1, 6));
      end
      run_script($sformatf("random%0d", n), 1'($urandom_range(0, 1)));
    end
    clear_in();
    tick();
  endtask

`ifdef LOAD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    set_script(K_DONE, 2, K_NONE, 1, K_DONE, 1, K_DONE, 1);
    run_script("timeout", 1'b0);
  endtask
`endif

  initial begin
    clear_in();
    test_reset();
    test_all_done();
    test_retry();
    test_retry_exhaust();
    test_both();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef LOAD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
